// File: rtl/tmds_rx_decoder.sv
// tmds_rx_decoder: three-lane TMDS word decoder with per-lane control-token alignment
// Ports:
//   clk_pix, rst            pixel clock, asynchronous active-high reset
//   tmds_b/tmds_g/tmds_r    10-bit words of lanes 0/1/2 (lane 0 carries hsync/vsync)
//   red/green/blue          decoded pixel data, zero outside active video
//   hsync/vsync/de          recovered sync bits and active-video flag
//   bitslip                 one-cycle slip request per lane (bit0 = lane 0)
//   locked                  all three lanes aligned
module tmds_rx_decoder #(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int SLIP_WAIT     = 16,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic [9:0] tmds_b,
  input  logic [9:0] tmds_g,
  input  logic [9:0] tmds_r,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [2:0] bitslip,
  output logic       locked
);
  localparam int M1 = CTRL_RUN > SEARCH_WINDOW ? CTRL_RUN : SEARCH_WINDOW;
  localparam int M2 = SLIP_WAIT > LOCK_TIMEOUT ? SLIP_WAIT : LOCK_TIMEOUT;
  localparam int W = $clog2((M1 > M2 ? M1 : M2) + 1);
  localparam logic [W-1:0] RUN_LIM  = W'(CTRL_RUN);
  localparam logic [W-1:0] WIN_LIM  = W'(SEARCH_WINDOW);
  localparam logic [W-1:0] WAIT_LIM = W'(SLIP_WAIT);
  localparam logic [W-1:0] TMO_LIM  = W'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {SEARCH, SLIP, LOCKED} state_t;

  logic [9:0]   word_in [3];
  logic [9:0]   word    [3];
  state_t       st      [3];
  state_t       st_n    [3];
  logic [W-1:0] run     [3];
  logic [W-1:0] run_n   [3];
  logic [W-1:0] cyc     [3];
  logic [W-1:0] cyc_n   [3];
  logic         tok0;
  logic         de_n;

  function automatic logic is_tok(input logic [9:0] q);
    return q[9:1] == 9'b001010101 || q[9:1] == 9'b110101010;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] q);
    logic [7:0] p;
    p = q[9] ? ~q[7:0] : q[7:0];
    return {p[7:1] ^ p[6:0] ^ {7{~q[8]}}, p[0]};
  endfunction

  function automatic logic [W-1:0] sat(input logic [W-1:0] x);
    return &x ? x : x + 1'b1;
  endfunction

  assign word_in[0] = tmds_b;
  assign word_in[1] = tmds_g;
  assign word_in[2] = tmds_r;

  // Aligners classify the raw input word so lock tracks the incoming stream;
  // cyc doubles as search window, slip wait and lock timeout counter.
  always_comb begin
    logic t;
    for (int i = 0; i < 3; i++) begin
      t = is_tok(word_in[i]);
      run_n[i] = t ? sat(run[i]) : '0;
      cyc_n[i] = sat(cyc[i]);
      st_n[i] = st[i];
      case (st[i])
        SEARCH:
          if (t && run_n[i] >= RUN_LIM) begin
            st_n[i] = LOCKED;
            run_n[i] = '0;
            cyc_n[i] = '0;
          end else if (cyc_n[i] >= WIN_LIM) begin
            st_n[i] = SLIP;
            run_n[i] = '0;
            cyc_n[i] = '0;
          end
        SLIP: begin
          run_n[i] = '0;
          if (cyc_n[i] >= WAIT_LIM) begin
            st_n[i] = SEARCH;
            cyc_n[i] = '0;
          end
        end
        default:
          if (t && run_n[i] >= RUN_LIM) cyc_n[i] = '0;
          else if (cyc_n[i] >= TMO_LIM) begin
            st_n[i] = SEARCH;
            run_n[i] = '0;
            cyc_n[i] = '0;
          end
      endcase
    end
  end

  assign tok0 = is_tok(word[0]);
  assign de_n = locked && !tok0;

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        word[i] <= '0;
        st[i] <= SEARCH;
        run[i] <= '0;
        cyc[i] <= '0;
      end
      red <= '0;
      green <= '0;
      blue <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
      de <= 1'b0;
      bitslip <= '0;
      locked <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        word[i] <= word_in[i];
        st[i] <= st_n[i];
        run[i] <= run_n[i];
        cyc[i] <= cyc_n[i];
        bitslip[i] <= st[i] == SEARCH && st_n[i] == SLIP;
      end
      locked <= st_n[0] == LOCKED && st_n[1] == LOCKED && st_n[2] == LOCKED;
      de <= de_n;
      blue <= de_n ? decode(word[0]) : '0;
      green <= de_n ? decode(word[1]) : '0;
      red <= de_n ? decode(word[2]) : '0;
      // C0 is bit 9 of every token; C1 is set when bits 9 and 0 agree
      if (st[0] == LOCKED && tok0) {hsync, vsync} <= {word[0][9], word[0][9] ~^ word[0][0]};
    end
  end
endmodule

// File: tb/tb_tmds_rx_decoder.sv
// tb_tmds_rx_decoder: randomized and directed check of tmds_rx_decoder against a behavioural model
module tb_tmds_rx_decoder;
  localparam int CTRL_RUN = 8;
  localparam int SEARCH_WINDOW = 2048;
  localparam int SLIP_WAIT = 16;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int S_SEARCH = 0;
  localparam int S_SLIP = 1;
  localparam int S_LOCK = 2;
  // index bit1 = C0 (hsync), bit0 = C1 (vsync)
  localparam logic [9:0] TOK [4] = '{10'b0010101011, 10'b0010101010, 10'b1101010100, 10'b1101010101};
  localparam logic [9:0] ROT = 10'b0101010110;

  logic clk_pix = 1'b0;
  logic rst = 1'b0;
  logic [9:0] tmds_b = '0, tmds_g = '0, tmds_r = '0;
  logic [7:0] red, green, blue;
  logic hsync, vsync, de, locked;
  logic [2:0] bitslip;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;
  logic check_en = 1'b0;

  int mst [3];
  int mrun [3];
  int mcyc [3];
  logic [9:0] ms1 [3];
  logic [7:0] e_red, e_green, e_blue;
  logic e_hs, e_vs, e_de, e_lk;
  logic [2:0] e_bs;

  tmds_rx_decoder #(
    .CTRL_RUN(CTRL_RUN), .SEARCH_WINDOW(SEARCH_WINDOW),
    .SLIP_WAIT(SLIP_WAIT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk_pix(clk_pix), .rst(rst), .tmds_b(tmds_b), .tmds_g(tmds_g), .tmds_r(tmds_r),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
    .de(de), .bitslip(bitslip), .locked(locked)
  );

  always #5 clk_pix = ~clk_pix;

  function automatic bit mtok(input logic [9:0] q);
    for (int i = 0; i < 4; i++) if (q == TOK[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] mctl(input logic [9:0] q);
    for (int i = 0; i < 4; i++) if (q == TOK[i]) return 2'(i);
    return 2'b00;
  endfunction

  function automatic logic [7:0] mdec(input logic [9:0] q);
    logic [7:0] d;
    bit p [8];
    for (int i = 0; i < 8; i++) p[i] = q[9] ? !q[i] : q[i];
    d[0] = p[0];
    for (int i = 1; i < 8; i++) d[i] = q[8] ? (p[i] != p[i-1]) : (p[i] == p[i-1]);
    return d;
  endfunction

  function automatic logic [9:0] rdata();
    logic [9:0] q;
    q = 10'($urandom);
    if (mtok(q)) q[9] = ~q[9];
    return q;
  endfunction

  function automatic logic [9:0] rtok();
    return TOK[$urandom_range(0, 3)];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, edges);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mst[i] = S_SEARCH;
      mrun[i] = 0;
      mcyc[i] = 0;
      ms1[i] = '0;
    end
    {e_red, e_green, e_blue, e_hs, e_vs, e_de, e_lk, e_bs} = '0;
  endtask

  // One clock edge: outputs come from the word captured last edge, lane states
  // advance on the word arriving now.
  task automatic model_edge(input logic [9:0] b, input logic [9:0] g, input logic [9:0] r);
    logic [9:0] x [3];
    bit q;
    x[0] = b;
    x[1] = g;
    x[2] = r;
    e_de = e_lk && !mtok(ms1[0]);
    e_blue = e_de ? mdec(ms1[0]) : 8'h00;
    e_green = e_de ? mdec(ms1[1]) : 8'h00;
    e_red = e_de ? mdec(ms1[2]) : 8'h00;
    if (mst[0] == S_LOCK && mtok(ms1[0])) {e_hs, e_vs} = mctl(ms1[0]);
    for (int i = 0; i < 3; i++) begin
      e_bs[i] = 1'b0;
      q = mtok(x[i]);
      if (mst[i] == S_SEARCH) begin
        mrun[i] = q ? mrun[i] + 1 : 0;
        mcyc[i]++;
        if (q && mrun[i] >= CTRL_RUN) begin
          mst[i] = S_LOCK; mrun[i] = 0; mcyc[i] = 0;
        end else if (mcyc[i] >= SEARCH_WINDOW) begin
          mst[i] = S_SLIP; mrun[i] = 0; mcyc[i] = 0; e_bs[i] = 1'b1;
        end
      end else if (mst[i] == S_SLIP) begin
        mcyc[i]++;
        if (mcyc[i] >= SLIP_WAIT) begin
          mst[i] = S_SEARCH; mcyc[i] = 0;
        end
      end else begin
        mrun[i] = q ? mrun[i] + 1 : 0;
        if (q && mrun[i] >= CTRL_RUN) mcyc[i] = 0;
        else begin
          mcyc[i]++;
          if (mcyc[i] >= LOCK_TIMEOUT) begin
            mst[i] = S_SEARCH; mrun[i] = 0; mcyc[i] = 0;
          end
        end
      end
      ms1[i] = x[i];
    end
    e_lk = mst[0] == S_LOCK && mst[1] == S_LOCK && mst[2] == S_LOCK;
  endtask

  task automatic step(input logic [9:0] b, input logic [9:0] g, input logic [9:0] r);
    tmds_b = b;
    tmds_g = g;
    tmds_r = r;
    @(posedge clk_pix);
    model_edge(b, g, r);
    edges++;
    @(negedge clk_pix);
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_red", red, 0);
    chk("rst_green", green, 0);
    chk("rst_blue", blue, 0);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_de", de, 0);
    chk("rst_bitslip", bitslip, 0);
    chk("rst_locked", locked, 0);
    model_reset();
    edges = 0;
    @(negedge clk_pix);
    @(negedge clk_pix);
    rst = 1'b0;
    check_en = 1'b1;
  endtask

  always @(negedge clk_pix) begin
    if (check_en) begin
      chk("red", red, e_red);
      chk("green", green, e_green);
      chk("blue", blue, e_blue);
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("de", de, e_de);
      chk("bitslip", bitslip, e_bs);
      chk("locked", locked, e_lk);
    end
  end

  initial begin
    int pulses, first, n;
    do_reset();
    // lock on eight blanking tokens
    for (int i = 0; i < 7; i++) step(TOK[0], TOK[0], TOK[0]);
    chk("lock_after_7", locked, 0);
    step(TOK[0], TOK[0], TOK[0]);
    chk("lock_after_8", locked, 1);
    step(TOK[0], TOK[0], TOK[0]);
    chk("token_de", de, 0);
    chk("token_hsync", hsync, 0);
    chk("token_vsync", vsync, 0);
    // data decode, two-cycle latency
    step(10'b0100000000, TOK[0], TOK[0]);
    step(TOK[0], TOK[0], TOK[0]);
    chk("blue_q8", blue, 8'h00);
    chk("de_q8", de, 1);
    step(10'b1100000000, TOK[0], TOK[0]);
    step(TOK[0], TOK[0], TOK[0]);
    chk("blue_q9q8", blue, 8'h01);
    chk("de_q9q8", de, 1);
    step(10'b1000000000, TOK[0], TOK[0]);
    step(TOK[0], TOK[0], TOK[0]);
    chk("blue_q9", blue, 8'hFF);
    // sync recovery
    step(TOK[3], TOK[0], TOK[0]);
    step(TOK[1], TOK[0], TOK[0]);
    chk("hsync_t11", hsync, 1);
    chk("vsync_t11", vsync, 1);
    step(TOK[0], TOK[0], TOK[0]);
    chk("hsync_t01", hsync, 0);
    chk("vsync_t01", vsync, 1);
    do_reset();
    // misaligned lane 0: one slip pulse after the window, then quiet during the wait
    pulses = 0;
    first = 0;
    for (int i = 0; i < SEARCH_WINDOW + SLIP_WAIT; i++) begin
      step(ROT, TOK[0], TOK[0]);
      if (bitslip[0] === 1'b1) begin
        pulses++;
        if (first == 0) first = edges;
      end
    end
    chk("slip_pulses", pulses, 1);
    chk("slip_edge", first, SEARCH_WINDOW);
    for (int i = 0; i < 7; i++) step(TOK[0], TOK[0], TOK[0]);
    chk("relock_7", locked, 0);
    step(TOK[0], TOK[0], TOK[0]);
    chk("relock_8", locked, 1);
    // reset during the slip pulse
    do_reset();
    for (int i = 0; i < SEARCH_WINDOW; i++) step(ROT, TOK[0], TOK[0]);
    chk("slip_before_rst", bitslip, 3'b001);
    do_reset();
    for (int i = 0; i < 7; i++) step(TOK[0], TOK[0], TOK[0]);
    chk("post_rst_lock_7", locked, 0);
    step(TOK[0], TOK[0], TOK[0]);
    chk("post_rst_lock_8", locked, 1);
    // lane 1 loses its control tokens
    for (int i = 0; i < LOCK_TIMEOUT - 1; i++) step(TOK[0], rdata(), TOK[0]);
    chk("tmo_hold", locked, 1);
    step(TOK[0], rdata(), TOK[0]);
    chk("tmo_drop", locked, 0);
    step(10'b0100000000, TOK[0], TOK[0]);
    step(TOK[0], TOK[0], TOK[0]);
    chk("tmo_de", de, 0);
    // random blanking/active traffic
    for (int blk = 0; blk < 40; blk++) begin
      n = (blk % 2 == 0) ? $urandom_range(10, 24) : $urandom_range(10, 90);
      for (int i = 0; i < n; i++) begin
        if (blk % 2 == 0) step(rtok(), rtok(), rtok());
        else step(($urandom_range(0, 7) == 0) ? rtok() : rdata(),
                  ($urandom_range(0, 15) == 0) ? 10'($urandom) : rdata(),
                  ($urandom_range(0, 7) == 0) ? rtok() : rdata());
      end
    end
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
